// File: rtl/riscv_wb_arbiter.sv
// Writeback arbiter for the register file's single write port: interleaves ALU/load
// writes with operand-read slots and tracks outstanding destination writes.
module riscv_wb_arbiter #(
  parameter int unsigned MAX_READ_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic [2:0]  ld_func3,
  input  logic        rs_req,
  output logic        rs_gnt,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        write_enable,
  output logic        mem_wr,
  output logic [2:0]  func3,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data_in,
  output logic [31:0] rd_pending
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_READ_STREAK);
  localparam logic [2:0] FUNC3_WORD = 3'b010;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_READ,
    SLOT_WRITE
  } slot_t;

  slot_t       slot;
  logic        write_waiting;
  logic        sel_ld;
  logic        last_ld;
  logic [3:0]  streak;
  logic [3:0]  streak_next;
  logic [4:0]  wr_rd;
  logic [31:0] pending_next;

  always_comb begin
    write_waiting = alu_valid | ld_valid;
    slot          = SLOT_IDLE;
    if (rs_req && write_waiting && (streak == STREAK_MAX)) slot = SLOT_WRITE;
    else if (rs_req)                                        slot = SLOT_READ;
    else if (write_waiting)                                 slot = SLOT_WRITE;

    // On a tie the source not granted last time wins.
    sel_ld    = ld_valid && (!alu_valid || !last_ld);
    wr_rd     = sel_ld ? ld_rd : alu_rd;
    alu_ready = !rst && (slot == SLOT_WRITE) && !sel_ld;
    ld_ready  = !rst && (slot == SLOT_WRITE) && sel_ld;

    streak_next = streak;
    if ((slot == SLOT_WRITE) || !write_waiting) streak_next = 4'd0;
    else if ((slot == SLOT_READ) && (streak < STREAK_MAX)) streak_next = streak + 4'd1;

    // Clear before set so a same-edge reissue of rd keeps the bit pending.
    pending_next = rd_pending;
    if ((slot == SLOT_WRITE) && (wr_rd != 5'd0)) pending_next[wr_rd] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0))           pending_next[iss_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_enable <= 1'b0;
      mem_wr       <= 1'b0;
      func3        <= 3'd0;
      rd_addr      <= 5'd0;
      rd_data_in   <= 32'd0;
      rs_gnt       <= 1'b0;
      rd_pending   <= 32'd0;
      streak       <= 4'd0;
      last_ld      <= 1'b0;
    end else begin
      write_enable <= (slot == SLOT_WRITE);
      mem_wr       <= (slot == SLOT_WRITE) && sel_ld;
      rs_gnt       <= (slot == SLOT_READ);
      rd_pending   <= pending_next;
      streak       <= streak_next;
      if (slot == SLOT_WRITE) begin
        last_ld    <= sel_ld;
        rd_addr    <= wr_rd;
        rd_data_in <= sel_ld ? ld_data : alu_data;
        func3      <= sel_ld ? ld_func3 : FUNC3_WORD;
      end
    end
  end

endmodule
